weight_filter: RTL and testbench



---
 rtl/weight_pkg.sv | 29 ++
 rtl/weight_filter_ma_ring.sv | 54 +++++
 rtl/weight_filter.sv | 172 +++++++++++++++++
 tb/tb_weight_filter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared types and default constants for the weight conditioning stage.
package weight_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      TARE = 2'd2
   } state_e;

   localparam int unsigned RAW_W           = 24;
   localparam int unsigned OUT_W           = 32;
   localparam int unsigned NET_W           = RAW_W + 1;
   localparam int unsigned SCALE_W         = 8;
   localparam int unsigned DEF_AVG_LOG2    = 3;
   localparam int unsigned DEF_SCALE_NUM   = 152;
   localparam int unsigned DEF_SCALE_SHIFT = 10;
   localparam int unsigned DEF_STABLE_TOL  = 2;
   localparam int unsigned DEF_STABLE_CNT  = 4;
   localparam int unsigned SUM_W           = RAW_W + DEF_AVG_LOG2;

   // Magnitude of a - b, one bit wider so the difference never wraps.
   function automatic logic [OUT_W:0] mag_diff(input logic signed [OUT_W-1:0] a,
                                                input logic signed [OUT_W-1:0] b);
      logic signed [OUT_W:0] d;
      d = (OUT_W + 1)'(a) - (OUT_W + 1)'(b);
      return d[OUT_W] ? (OUT_W + 1)'(-d) : (OUT_W + 1)'(d);
   endfunction

endpackage

// File: rtl/weight_filter_ma_ring.sv
// Moving-average ring: sample buffer, write pointer, running sum and window counter.
module ma_ring
   import weight_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    sample_valid_i,
   input  logic signed [RAW_W-1:0] sample_i,
   input  logic                    cnt_clr_i,
   output logic signed [RAW_W-1:0] avg_c_o,
   output logic                    win_hit_c_o
);

   localparam int unsigned W      = 1 << AVG_LOG2;
   localparam int unsigned RSUM_W = RAW_W + AVG_LOG2;
   localparam int unsigned CNT_W  = AVG_LOG2 + 1;

   logic signed [RAW_W-1:0]  ring_q [W];
   logic [AVG_LOG2-1:0]      wr_q;
   logic signed [RSUM_W-1:0] sum_q;
   logic signed [RSUM_W-1:0] sum_d;
   logic [CNT_W-1:0]         cnt_q;

   // The oldest sample leaves the window as the new one enters.
   assign sum_d       = sum_q + RSUM_W'(sample_i) - RSUM_W'(ring_q[wr_q]);
   assign avg_c_o     = RAW_W'(sum_q >>> AVG_LOG2);
   assign win_hit_c_o = sample_valid_i && !cnt_clr_i && (cnt_q == CNT_W'(W - 1));

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(W); i++) begin
            ring_q[i] <= '0;
         end
         wr_q  <= '0;
         sum_q <= '0;
         cnt_q <= '0;
      end else begin
         if (sample_valid_i) begin
            sum_q          <= sum_d;
            ring_q[wr_q]   <= sample_i;
            wr_q           <= wr_q + AVG_LOG2'(1);
         end
         // Saturates at W so one window yields exactly one hit.
         if (cnt_clr_i) begin
            cnt_q <= '0;
         end else if (sample_valid_i && (cnt_q != CNT_W'(W))) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/weight_filter.sv
// Averages raw HX711 codes, applies tare, scales to grams and flags settled readings.
module weight_filter
   import weight_pkg::*;
#(
   parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
   parameter int unsigned SCALE_NUM   = DEF_SCALE_NUM,
   parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int unsigned STABLE_TOL  = DEF_STABLE_TOL,
   parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    raw_valid,
   input  logic [RAW_W-1:0]        raw_data,
   input  logic                    tare_req,
   output logic signed [OUT_W-1:0] weight_g,
   output logic                    weight_valid,
   output logic                    stable,
   output logic                    tare_busy,
   output logic signed [RAW_W-1:0] avg_raw
);

   localparam int unsigned PROD_W = NET_W + SCALE_W + 1;
   localparam int unsigned SCNT_W = $clog2(STABLE_CNT + 1);
   localparam logic signed [PROD_W-1:0] SCALE_S = PROD_W'(SCALE_NUM);

   state_e                  state_q;
   logic                    pend_q;
   logic                    tare_busy_q;
   logic                    stable_q;
   logic [SCNT_W-1:0]       scnt_q;
   logic                    v0_q, v1_q, v2_q, wv_q;
   logic                    ld0_q, ld1_q, ld2_q;
   logic signed [RAW_W-1:0] avg1_q, avg2_q, avg_raw_q;
   logic signed [RAW_W-1:0] tare_off_q;
   logic signed [NET_W-1:0] net_q;
   logic signed [OUT_W-1:0] weight_q;

   logic signed [RAW_W-1:0]  avg_c;
   logic                     hit_c;
   logic                     enter_tare_c;
   logic                     emit_c;
   logic                     ld_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [OUT_W-1:0]  weight_c;
   logic                     tol_ok_c;
   logic [SCNT_W-1:0]        scnt_nxt_c;

   ma_ring #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_ring (
      .clk_50         (clk_50),
      .rst_n          (rst_n),
      .sample_valid_i (raw_valid),
      .sample_i       ($signed(raw_data)),
      .cnt_clr_i      (enter_tare_c),
      .avg_c_o        (avg_c),
      .win_hit_c_o    (hit_c)
   );

   // A pending tare from FILL is serviced on the first RUN cycle.
   assign enter_tare_c = (state_q == RUN) && (tare_req || pend_q);
   assign emit_c       = raw_valid && ((state_q != FILL) || hit_c);
   assign ld_c         = raw_valid && (state_q == TARE) && hit_c;

   assign prod_c   = PROD_W'(net_q) * SCALE_S;
   assign weight_c = OUT_W'(prod_c >>> SCALE_SHIFT);
   assign tol_ok_c = mag_diff(weight_c, weight_q) <= (OUT_W + 1)'(STABLE_TOL);

   always_comb begin
      scnt_nxt_c = '0;
      if (tol_ok_c) begin
         scnt_nxt_c = (scnt_q == SCNT_W'(STABLE_CNT)) ? scnt_q : scnt_q + SCNT_W'(1);
      end
   end

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         state_q     <= FILL;
         pend_q      <= 1'b0;
         tare_busy_q <= 1'b0;
         stable_q    <= 1'b0;
         scnt_q      <= '0;
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         wv_q        <= 1'b0;
         ld0_q       <= 1'b0;
         ld1_q       <= 1'b0;
         ld2_q       <= 1'b0;
         avg1_q      <= '0;
         avg2_q      <= '0;
         avg_raw_q   <= '0;
         tare_off_q  <= '0;
         net_q       <= '0;
         weight_q    <= '0;
      end else begin
         v0_q  <= emit_c;
         ld0_q <= ld_c;

         // P1: average; the tare offset captures the same value on the closing sample.
         v1_q  <= v0_q;
         ld1_q <= ld0_q;
         if (v0_q) begin
            avg1_q <= avg_c;
         end
         if (ld0_q) begin
            tare_off_q <= avg_c;
         end

         // P2: net code.
         v2_q  <= v1_q;
         ld2_q <= ld1_q;
         if (v1_q) begin
            net_q  <= NET_W'(avg1_q) - NET_W'(tare_off_q);
            avg2_q <= avg1_q;
         end

         // P3: grams.
         wv_q <= v2_q;
         if (v2_q) begin
            weight_q  <= weight_c;
            avg_raw_q <= avg2_q;
         end

         if (enter_tare_c) begin
            scnt_q   <= '0;
            stable_q <= 1'b0;
         end else if (v2_q) begin
            if (state_q == RUN) begin
               scnt_q   <= scnt_nxt_c;
               stable_q <= (scnt_nxt_c == SCNT_W'(STABLE_CNT));
            end else begin
               stable_q <= 1'b0;
            end
         end

         unique case (state_q)
            FILL: begin
               if (tare_req) begin
                  pend_q <= 1'b1;
               end
               if (hit_c) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (enter_tare_c) begin
                  state_q     <= TARE;
                  pend_q      <= 1'b0;
                  tare_busy_q <= 1'b1;
               end
            end
            TARE: begin
               // Leave when the result computed with the new offset emerges.
               if (ld2_q) begin
                  state_q     <= RUN;
                  tare_busy_q <= 1'b0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign weight_g     = weight_q;
   assign weight_valid = wv_q;
   assign stable       = stable_q;
   assign tare_busy    = tare_busy_q;
   assign avg_raw      = avg_raw_q;

endmodule

// File: tb/tb_weight_filter.sv
// Self-checking bench for weight_filter: directed sequences, a constant-fill table and random traffic.
module tb_weight_filter;

   localparam int W = 8;

   logic               clk_50 = 1'b0;
   logic               rst_n;
   logic               raw_valid;
   logic [23:0]        raw_data;
   logic               tare_req;
   logic signed [31:0] weight_g;
   logic               weight_valid;
   logic               stable;
   logic               tare_busy;
   logic signed [23:0] avg_raw;

   always #10 clk_50 = ~clk_50;

   weight_filter dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .raw_valid    (raw_valid),
      .raw_data     (raw_data),
      .tare_req     (tare_req),
      .weight_g     (weight_g),
      .weight_valid (weight_valid),
      .stable       (stable),
      .tare_busy    (tare_busy),
      .avg_raw      (avg_raw)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (sample-sequence level) ----------------
   typedef struct {
      longint avg;
      longint wt;
      bit     stb;
      bit     busy;
   } exp_t;

   exp_t   expq[$];
   longint m_win[W];
   int     m_wp, m_nfill, m_mode, m_tcnt, m_scnt;  // mode: 0 fill, 1 run, 2 tare
   bit     m_pend;
   longint m_tare_off, m_prev;

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint sx24(input logic [23:0] d);
      return d[23] ? longint'(d) - 64'sd16777216 : longint'(d);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < W; i++) m_win[i] = 0;
      m_wp = 0; m_nfill = 0; m_mode = 0; m_tcnt = 0; m_scnt = 0;
      m_pend = 0; m_tare_off = 0; m_prev = 0;
      expq.delete();
   endfunction

   function automatic bit model_tare();
      if (m_mode == 1) begin
         m_mode = 2; m_tcnt = 0; m_scnt = 0;
         return 1'b1;
      end
      if (m_mode == 0) m_pend = 1;
      return 1'b0;
   endfunction

   function automatic void model_sample(input logic [23:0] d, input bit counted);
      longint s, avg, wt, diff;
      bit out_tare, done;
      exp_t e;
      out_tare = 0; done = 0;
      m_win[m_wp] = sx24(d);
      m_wp = (m_wp + 1) % W;
      s = 0;
      for (int i = 0; i < W; i++) s += m_win[i];
      avg = floor_div(s, W);
      if (m_mode == 0) begin
         m_nfill++;
         if (m_nfill < W) return;
         m_mode = 1;
         if (m_pend) begin
            m_pend = 0; m_mode = 2; m_tcnt = 0; m_scnt = 0; out_tare = 1;
         end
      end else if (m_mode == 2) begin
         out_tare = 1;
         if (counted) begin
            m_tcnt++;
            if (m_tcnt == W) begin
               m_tare_off = avg; m_mode = 1; done = 1;
            end
         end
      end
      wt = floor_div((avg - m_tare_off) * 152, 1024);
      if (out_tare) begin
         e.stb = 0;
      end else begin
         diff = wt - m_prev;
         if (diff < 0) diff = -diff;
         if (diff <= 2) m_scnt = (m_scnt < 4) ? m_scnt + 1 : 4;
         else m_scnt = 0;
         e.stb = (m_scnt == 4);
      end
      e.busy = out_tare && !done;
      e.avg  = avg;
      e.wt   = wt;
      m_prev = wt;
      expq.push_back(e);
   endfunction

   // ---------------- output monitor ----------------
   int     n_valid = 0;
   longint last_avg = 0, last_w = 0;
   exp_t   mon_e;

   always @(negedge clk_50) begin
      if (rst_n && weight_valid) begin
         n_valid++;
         last_avg = avg_raw;
         last_w   = weight_g;
         if (expq.size() == 0) begin
            chk("stray_weight_valid", 1, 0);
         end else begin
            mon_e = expq.pop_front();
            chk("avg_raw", avg_raw, mon_e.avg);
            chk("weight_g", weight_g, mon_e.wt);
            chk("stable", stable, longint'(mon_e.stb));
            chk("tare_busy", tare_busy, longint'(mon_e.busy));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [23:0] d, input bit tr);
      bit ent;
      ent = 0;
      raw_valid = 1'b1; raw_data = d; tare_req = tr;
      if (tr) ent = model_tare();
      model_sample(d, !ent);
      tick();
      raw_valid = 1'b0; tare_req = 1'b0;
   endtask

   task automatic tare_only();
      bit ent;
      tare_req = 1'b1;
      ent = model_tare();
      tick();
      tare_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; raw_valid = 1'b0; tare_req = 1'b0;
      model_reset();
      tick();
      chk("rst_weight_g", weight_g, 0);
      chk("rst_weight_valid", weight_valid, 0);
      chk("rst_stable", stable, 0);
      chk("rst_tare_busy", tare_busy, 0);
      chk("rst_avg_raw", avg_raw, 0);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [23:0] raw;
      longint      avg;
      longint      wt;
   } vec_t;

   vec_t tbl[8];
   int   nv0;
   int   base;

   initial begin
      tbl[0] = '{24'h001000, 4096, 608};
      tbl[1] = '{24'hFFF000, -4096, -608};
      tbl[2] = '{24'h000000, 0, 0};
      tbl[3] = '{24'h7FFFFF, 8388607, 1245183};
      tbl[4] = '{24'h800000, -8388608, -1245184};
      tbl[5] = '{24'h000007, 7, 1};
      tbl[6] = '{24'hFFFFF9, -7, -2};
      tbl[7] = '{24'h000400, 1024, 152};

      rst_n = 1'b0; raw_valid = 1'b0; raw_data = '0; tare_req = 1'b0;
      idle(2);
      do_reset();

      // Fill: silent for 7 samples, first result 3 cycles after the 8th.
      for (int i = 0; i < 7; i++) send(24'h001000, 0);
      idle(4);
      chk("fill_no_valid", n_valid, 0);
      send(24'h001000, 0);
      tick(); chk("lat_n1_valid", weight_valid, 0);
      tick(); chk("lat_n2_valid", weight_valid, 0);
      tick(); chk("lat_n3_valid", weight_valid, 1);
      chk("fill_avg", avg_raw, 4096);
      chk("fill_weight", weight_g, 608);
      for (int i = 0; i < 3; i++) send(24'h001000, 0);
      idle(4);
      chk("stable_before_4th", stable, 0);
      send(24'h001000, 0);
      idle(4);
      chk("stable_at_4th", stable, 1);

      // Step disturbs the reading.
      send(24'h002000, 0);
      idle(4);
      chk("step_avg", last_avg, 4608);
      chk("step_weight", last_w, 684);
      chk("step_stable", stable, 0);

      // Tare window.
      tare_only();
      chk("tare_busy_rise", tare_busy, 1);
      for (int i = 0; i < W; i++) begin
         send(24'h001000, 0);
         chk("tare_busy_hold", tare_busy, 1);
      end
      idle(3);
      chk("tare_result_valid", weight_valid, 1);
      chk("tare_result_weight", weight_g, 0);
      chk("tare_busy_fall", tare_busy, 0);
      for (int i = 0; i < 4; i++) send(24'h001000, 0);
      idle(4);
      chk("stable_after_tare", stable, 1);

      // Tare requested during FILL stays pending until RUN.
      do_reset();
      for (int i = 0; i < 3; i++) send(24'h001000, 0);
      tare_only();
      chk("pend_no_busy", tare_busy, 0);
      for (int i = 0; i < 5; i++) send(24'h001000, 0);
      chk("pend_busy_at_run", tare_busy, 0);
      tick();
      chk("pend_busy_next", tare_busy, 1);
      for (int i = 0; i < W; i++) send(24'h001000, 0);
      idle(3);
      chk("pend_tare_weight", weight_g, 0);
      chk("pend_busy_fall", tare_busy, 0);

      // Reset mid-TARE with the pipeline busy.
      idle(4);
      tare_only();
      for (int i = 0; i < 4; i++) send(24'h003000, 0);
      do_reset();
      nv0 = n_valid;
      idle(6);
      chk("reset_no_stray", n_valid, nv0);
      for (int i = 0; i < W; i++) send(24'h001000, 0);
      idle(4);
      chk("reset_tare_cleared", last_w, 608);

      // Constant-fill table covering sign and rounding boundaries.
      for (int k = 0; k < 8; k++) begin
         do_reset();
         for (int i = 0; i < W; i++) send(tbl[k].raw, 0);
         idle(4);
         chk($sformatf("tbl%0d_avg", k), last_avg, tbl[k].avg);
         chk($sformatf("tbl%0d_weight", k), last_w, tbl[k].wt);
      end

      // Random traffic against the model.
      do_reset();
      base = 4096;
      for (int it = 0; it < 600; it++) begin
         int r;
         int v;
         r = int'($urandom_range(0, 99));
         if (r < 4 && m_mode != 0) begin
            idle(5);
            if ($urandom_range(0, 1) == 1) send(24'($urandom), 1);
            else tare_only();
         end else if (r < 20) begin
            idle(1);
         end else if (r < 23) begin
            base = int'($urandom_range(0, 2097151)) - 1048576;
         end else if (r < 26) begin
            send(24'($urandom), 0);
         end else begin
            v = base + int'($urandom_range(0, 6)) - 3;
            send(24'(v), 0);
         end
      end
      idle(6);
      chk("queue_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
